// File: rtl/post_adder_accumulator_pkg.sv
// rtl/post_adder_accumulator_pkg.sv - shared select codes, OPMODE bit indices and widths
package post_adder_accumulator_pkg;
   localparam int DATA_W  = 48;
   localparam int OPM_SUB = 7;
   localparam int OPM_CIN = 5;

   typedef enum logic [1:0] {
      X_ZERO = 2'b00,
      X_M    = 2'b01,
      X_P    = 2'b10,
      X_DAB  = 2'b11
   } x_sel_e;

   typedef enum logic [1:0] {
      Z_ZERO = 2'b00,
      Z_PCIN = 2'b01,
      Z_P    = 2'b10,
      Z_C    = 2'b11
   } z_sel_e;
endpackage

// File: rtl/dsp_reg_mux.sv
// rtl/dsp_reg_mux.sv - pipeline register with clock enable, sync reset and bypass mux
module dsp_reg_mux #(
   parameter int WIDTH = 1,
   parameter int REG   = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ce,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);
   logic [WIDTH-1:0] q_r;

   always_ff @(posedge clk) begin
      if (rst)
         q_r <= '0;
      else if (ce)
         q_r <= d;
   end

   assign q = (REG != 0) ? q_r : d;
endmodule

// File: rtl/post_adder_accumulator.sv
// rtl/post_adder_accumulator.sv - DSP48A1 post-adder: X/Z select, 49-bit add/sub, P feedback
module post_adder_accumulator
   import post_adder_accumulator_pkg::*;
#(
   parameter int    OPMODEREG   = 1,
   parameter int    CARRYINREG  = 1,
   parameter int    CREG        = 1,
   parameter int    PREG        = 1,
   parameter int    CARRYOUTREG = 1,
   parameter string CARRYINSEL  = "OPMODE5"
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              CE,
   input  logic [7:0]        OPMODE,
   input  logic [35:0]       M,
   input  logic [DATA_W-1:0] DAB,
   input  logic [DATA_W-1:0] C,
   input  logic [DATA_W-1:0] PCIN,
   input  logic              CARRYIN,
   output logic [DATA_W-1:0] P,
   output logic [DATA_W-1:0] PCOUT,
   output logic              CARRYOUT,
   output logic              CARRYOUTF
);
   localparam bit CIN_OPM = (CARRYINSEL == "OPMODE5");
   localparam bit CIN_EXT = (CARRYINSEL == "CARRYIN");

   logic [7:0]        opmode_r;
   logic [DATA_W-1:0] c_r;
   logic              cin_d;
   logic              cin;
   logic [DATA_W-1:0] p_fb;
   logic [DATA_W-1:0] x;
   logic [DATA_W-1:0] z;
   logic [DATA_W:0]   sum;

   dsp_reg_mux #(.WIDTH(8), .REG(OPMODEREG)) u_opmode_reg (
      .clk(CLK), .rst(RST), .ce(CE), .d(OPMODE), .q(opmode_r)
   );

   dsp_reg_mux #(.WIDTH(DATA_W), .REG(CREG)) u_c_reg (
      .clk(CLK), .rst(RST), .ce(CE), .d(C), .q(c_r)
   );

   // A registered carry-in samples raw OPMODE[5] so it lines up with the OPMODE register
   assign cin_d = CIN_OPM ? ((CARRYINREG != 0) ? OPMODE[OPM_CIN] : opmode_r[OPM_CIN])
                          : (CIN_EXT ? CARRYIN : 1'b0);

   dsp_reg_mux #(.WIDTH(1), .REG(CARRYINREG)) u_cin_reg (
      .clk(CLK), .rst(RST), .ce(CE), .d(cin_d), .q(cin)
   );

   // Without PREG there is no register to feed back, so the P selection reads as zero
   generate
      if (PREG != 0) begin : g_fb
         assign p_fb = P;
      end else begin : g_no_fb
         assign p_fb = '0;
      end
   endgenerate

   always_comb begin
      x = '0;
      case (x_sel_e'(opmode_r[1:0]))
         X_M:     x = {12'b0, M};
         X_P:     x = p_fb;
         X_DAB:   x = DAB;
         default: x = '0;
      endcase
   end

   always_comb begin
      z = '0;
      case (z_sel_e'(opmode_r[3:2]))
         Z_PCIN:  z = PCIN;
         Z_P:     z = p_fb;
         Z_C:     z = c_r;
         default: z = '0;
      endcase
   end

   always_comb begin
      sum = '0;
      if (opmode_r[OPM_SUB])
         sum = {1'b0, z} - ({1'b0, x} + {{DATA_W{1'b0}}, cin});
      else
         sum = {1'b0, z} + {1'b0, x} + {{DATA_W{1'b0}}, cin};
   end

   dsp_reg_mux #(.WIDTH(DATA_W), .REG(PREG)) u_p_reg (
      .clk(CLK), .rst(RST), .ce(CE), .d(sum[DATA_W-1:0]), .q(P)
   );

   dsp_reg_mux #(.WIDTH(1), .REG(CARRYOUTREG)) u_co_reg (
      .clk(CLK), .rst(RST), .ce(CE), .d(sum[DATA_W]), .q(CARRYOUT)
   );

   assign PCOUT     = P;
   assign CARRYOUTF = CARRYOUT;
endmodule

// File: tb/tb_post_adder_accumulator.sv
// tb/tb_post_adder_accumulator.sv - directed self-checking bench for post_adder_accumulator
module tb_post_adder_accumulator;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        ce = 1'b1;
   logic [7:0]  opmode = '0;
   logic [35:0] m = '0;
   logic [47:0] dab = '0;
   logic [47:0] c = '0;
   logic [47:0] pcin = '0;
   logic        carryin = 1'b0;

   logic [47:0] p1, pc1, p2, pc2, p3, pc3;
   logic        co1, cof1, co2, cof2, co3, cof3;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   post_adder_accumulator u_dflt (
      .CLK(clk), .RST(rst), .CE(ce), .OPMODE(opmode), .M(m), .DAB(dab), .C(c),
      .PCIN(pcin), .CARRYIN(carryin), .P(p1), .PCOUT(pc1), .CARRYOUT(co1), .CARRYOUTF(cof1)
   );

   post_adder_accumulator #(.CARRYINSEL("CARRYIN")) u_extcin (
      .CLK(clk), .RST(rst), .CE(ce), .OPMODE(opmode), .M(m), .DAB(dab), .C(c),
      .PCIN(pcin), .CARRYIN(carryin), .P(p2), .PCOUT(pc2), .CARRYOUT(co2), .CARRYOUTF(cof2)
   );

   post_adder_accumulator #(.PREG(0), .CARRYOUTREG(0)) u_nopreg (
      .CLK(clk), .RST(rst), .CE(ce), .OPMODE(opmode), .M(m), .DAB(dab), .C(c),
      .PCIN(pcin), .CARRYIN(carryin), .P(p3), .PCOUT(pc3), .CARRYOUT(co3), .CARRYOUTF(cof3)
   );

   task automatic chk(input string tag, input logic [48:0] got, input logic [48:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      chk("pcout1", {1'b0, pc1}, {1'b0, p1});
      chk("coutf1", {48'b0, cof1}, {48'b0, co1});
      chk("pcout2", {1'b0, pc2}, {1'b0, p2});
      chk("pcout3", {1'b0, pc3}, {1'b0, p3});
      chk("coutf3", {48'b0, cof3}, {48'b0, co3});
   end

   initial begin
      // reset with random inputs
      for (int i = 0; i < 2; i++) begin
         opmode = 8'($urandom);
         m      = {4'($urandom), 32'($urandom)};
         dab    = {16'($urandom), 32'($urandom)};
         c      = {16'($urandom), 32'($urandom)};
         pcin   = {16'($urandom), 32'($urandom)};
         tick(1);
         chk("rst_p", {1'b0, p1}, 49'd0);
         chk("rst_co", {48'b0, co1}, 49'd0);
      end
      opmode = 8'h00; m = '0; dab = '0; c = '0; pcin = '0;
      rst = 1'b0;
      tick(1);
      chk("post_rst_p", {1'b0, p1}, 49'd0);

      // add then subtract, OPMODE registered
      opmode = 8'h0D; m = 36'd5; c = 48'd10;
      tick(2);
      chk("add_c_m", {co1, p1}, 49'd15);
      opmode = 8'h8D;
      tick(1);
      chk("old_mode_pending", {co1, p1}, 49'd15);
      tick(1);
      chk("sub_c_m", {co1, p1}, 49'd5);

      // accumulate P += M
      rst = 1'b1; opmode = 8'h09; m = 36'd3;
      tick(1);
      chk("acc_rst", {1'b0, p1}, 49'd0);
      rst = 1'b0;
      tick(1);
      chk("acc_start", {1'b0, p1}, 49'd0);
      for (int k = 1; k <= 4; k++) begin
         tick(1);
         chk("acc_step", {co1, p1}, 49'(3 * k));
      end
      ce = 1'b0;
      tick(2);
      chk("acc_hold", {co1, p1}, 49'd12);
      rst = 1'b1;
      tick(1);
      chk("rst_ce0", {co1, p1}, 49'd0);
      rst = 1'b0; ce = 1'b1;
      tick(2);
      chk("acc_resume", {co1, p1}, 49'd3);

      // wrap via DAB and via OPMODE[5] carry-in
      opmode = 8'h0F; c = 48'hFFFF_FFFF_FFFF; dab = 48'd1;
      tick(2);
      chk("wrap_dab", {co1, p1}, {1'b1, 48'd0});
      opmode = 8'h8D; c = 48'd100; m = 36'd1;
      tick(2);
      chk("sub_mid", {co1, p1}, 49'd99);
      opmode = 8'h2C; c = 48'hFFFF_FFFF_FFFF;
      tick(2);
      chk("wrap_cin", {co1, p1}, {1'b1, 48'd0});

      // borrow
      opmode = 8'h8D; c = 48'd2; m = 36'd3;
      tick(2);
      chk("borrow", {co1, p1}, {1'b1, 48'hFFFF_FFFF_FFFF});

      // external carry-in select
      opmode = 8'h00; carryin = 1'b1;
      tick(2);
      chk("ext_cin", {co2, p2}, 49'd1);
      chk("opm5_cin_off", {co1, p1}, 49'd0);
      carryin = 1'b0;

      // PREG=0: X=P reads zero, P follows combinationally
      opmode = 8'h0E; c = 48'd7;
      tick(1);
      chk("nopreg_xp_c", {co3, p3}, 49'd7);
      opmode = 8'h0A;
      tick(1);
      chk("nopreg_xp_zp", {co3, p3}, 49'd0);
      opmode = 8'h0D; m = 36'd4;
      tick(1);
      m = 36'd6;
      #1;
      chk("nopreg_comb_m", {co3, p3}, 49'd13);

      tick(1);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
